// File: rtl/line_burst_pkg.sv
// Shared types and constants for the line-to-burst memory adaptor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package line_burst_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int LINE_BYTES       = 32;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int DEF_LINE_WIDTH   = 256;
  localparam int DEF_BURST_LEN    = 4;
  localparam int DEF_BEAT_W       = DEF_LINE_WIDTH / DEF_BURST_LEN;

  localparam logic [31:0] LINE_OFFSET_MASK = (32'd1 << LINE_OFFSET_BITS) - 32'd1;

  // Clear the byte-offset bits so the burst always starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~LINE_OFFSET_MASK;
  endfunction

endpackage

// File: rtl/line_burst_adaptor_reg.sv
// Generic load-enable register with asynchronous active-low clear.
// Latency: 1 cycle from en to q.
// Backpressure: none; loads whenever en is high.
module line_burst_adaptor_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  // Hold value until a load is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else if (en) q_q <= d;
  end

  assign q = q_q;

endmodule

// File: rtl/line_burst_adaptor.sv
// Converts one line read/write into a BURST_LEN-beat burst on the memory port (optional LINE_BURST_TIMEOUT_EN).
// Latency: request -> burst 1 cycle; last beat -> line_resp_o 1 cycle; BURST_LEN+2 cycles minimum.
// Backpressure: requester holds its request until line_resp_o; memory paces beats with burst_resp_i.
module line_burst_adaptor
  import line_burst_pkg::*;
#(
  parameter int LINE_WIDTH     = DEF_LINE_WIDTH,
  parameter int BURST_LEN      = DEF_BURST_LEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           line_read_i,
  input  logic                           line_write_i,
  input  logic [31:0]                    line_address_i,
  input  logic [LINE_WIDTH-1:0]          line_wdata_i,
  output logic [LINE_WIDTH-1:0]          line_rdata_o,
  output logic                           line_resp_o,
  output logic                           burst_read_o,
  output logic                           burst_write_o,
  output logic [31:0]                    burst_address_o,
  output logic [LINE_WIDTH/BURST_LEN-1:0] burst_wdata_o,
  input  logic [LINE_WIDTH/BURST_LEN-1:0] burst_rdata_i,
  input  logic                           burst_resp_i,
  output logic                           err_o
);

  localparam int BEAT_W = LINE_WIDTH / BURST_LEN;
  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [BURST_LEN-1:0][BEAT_W-1:0]  wdata_q, wdata_d;
  logic [BURST_LEN-1:0][BEAT_W-1:0]  rdata_q, rdata_d;
  logic                              resp_q, resp_d;
  logic                              burst_read_q, burst_read_d;
  logic                              burst_write_q, burst_write_d;
  logic                              addr_en;
  logic [31:0]                       addr_d;
  logic [31:0]                       addr_q;
  logic                              abort;

  // Address is loaded on acceptance and cleared when the burst ends, so it reads 0 outside a burst.
  line_burst_adaptor_reg #(.W(32)) u_addr_reg (
    .clk (clk),
    .rst (rst),
    .en  (addr_en),
    .d   (addr_d),
    .q   (addr_q)
  );

`ifdef LINE_BURST_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              err_q, err_d;

  // Count consecutive burst cycles without a beat; restarts on each beat and outside bursts.
  always_comb begin
    idle_d = '0;
    err_d  = 1'b0;
    abort  = 1'b0;
    if ((state_q == RD_BURST || state_q == WR_BURST) && !burst_resp_i) begin
      idle_d = idle_q + IDLE_W'(1);
      if (idle_d == IDLE_W'(TIMEOUT_CYCLES)) begin
        abort = 1'b1;
        err_d = 1'b1;
      end
    end
  end

  // Idle-beat counter and error pulse flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  // Next-state and next-output decode; read wins over write when both are pending.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    resp_d        = 1'b0;
    burst_read_d  = 1'b0;
    burst_write_d = 1'b0;
    addr_en       = 1'b0;
    addr_d        = '0;
    case (state_q)
      IDLE: begin
        if (line_read_i) begin
          state_d      = RD_BURST;
          cnt_d        = '0;
          burst_read_d = 1'b1;
          addr_en      = 1'b1;
          addr_d       = line_align(line_address_i);
        end else if (line_write_i) begin
          state_d       = WR_BURST;
          cnt_d         = '0;
          wdata_d       = line_wdata_i;
          burst_write_d = 1'b1;
          addr_en       = 1'b1;
          addr_d        = line_align(line_address_i);
        end
      end
      RD_BURST: begin
        burst_read_d = 1'b1;
        if (burst_resp_i) begin
          rdata_d[cnt_q] = burst_rdata_i;
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d      = DONE;
            burst_read_d = 1'b0;
            resp_d       = 1'b1;
            addr_en      = 1'b1;
          end
        end
      end
      WR_BURST: begin
        burst_write_d = 1'b1;
        if (burst_resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d       = DONE;
            burst_write_d = 1'b0;
            resp_d        = 1'b1;
            addr_en       = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d       = DONE;
      burst_read_d  = 1'b0;
      burst_write_d = 1'b0;
      resp_d        = 1'b1;
      addr_en       = 1'b1;
      addr_d        = '0;
    end
  end

  // FSM state, beat counter, line buffers and registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      resp_q        <= 1'b0;
      burst_read_q  <= 1'b0;
      burst_write_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      resp_q        <= resp_d;
      burst_read_q  <= burst_read_d;
      burst_write_q <= burst_write_d;
    end
  end

  assign line_rdata_o    = rdata_q;
  assign line_resp_o     = resp_q;
  assign burst_read_o    = burst_read_q;
  assign burst_write_o   = burst_write_q;
  assign burst_address_o = addr_q;
  assign burst_wdata_o   = wdata_q[cnt_q];

endmodule
